// File: rtl/ghostchip_pkg.sv
// ghostchip_pkg
//   Shared definitions for the sprite draw engine: the FSM state encoding
//   and the playfield geometry for the low-res (64x32) and high-res (128x64)
//   modes.
//   Ports: none (package).
package ghostchip_pkg;

  localparam int LORES_W    = 64;
  localparam int LORES_H    = 32;
  localparam int HIRES_W    = 128;
  localparam int HIRES_H    = 64;
  localparam int SPR16_ROWS = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FWAIT,
    ST_PIX,
    ST_PRD,
    ST_PWR,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sprite_draw_if.sv
// sprite_draw_if
//   Memory-side bus of the sprite draw engine. It groups the sprite RAM read
//   port and the vram read/modify/write port.
//   master: the draw engine (drives ram_addr, vram_hpos, vram_vpos,
//           vram_pixeli, vram_we; receives ram_dout, vram_pixelo)
//   slave : the memories (opposite directions)
interface sprite_draw_if #(
  parameter int RAM_AW  = 12,
  parameter int VRAM_XW = 7,
  parameter int VRAM_YW = 6
);
  logic [RAM_AW-1:0]  ram_addr;
  logic [7:0]         ram_dout;
  logic [VRAM_XW-1:0] vram_hpos;
  logic [VRAM_YW-1:0] vram_vpos;
  logic [1:0]         vram_pixeli;
  logic [1:0]         vram_pixelo;
  logic               vram_we;

  modport master (
    output ram_addr, vram_hpos, vram_vpos, vram_pixeli, vram_we,
    input  ram_dout, vram_pixelo
  );

  modport slave (
    input  ram_addr, vram_hpos, vram_vpos, vram_pixeli, vram_we,
    output ram_dout, vram_pixelo
  );
endinterface

// File: rtl/sprite_clip.sv
// sprite_clip
//   Combinational placement of one sprite pixel. Adds the sprite column/row
//   to the already wrapped origin and flags pixels that fall off the right
//   or bottom edge of the active field (sprites clip, they do not wrap).
//   Ports: x0/y0 origin, col/row offset inside sprite, hires field select;
//          hpos/vpos vram coordinates, clipped = pixel outside the field.
module sprite_clip
  import ghostchip_pkg::*;
(
  input  logic [6:0] x0,
  input  logic [5:0] y0,
  input  logic [3:0] col,
  input  logic [3:0] row,
  input  logic       hires,
  output logic [6:0] hpos,
  output logic [5:0] vpos,
  output logic       clipped
);
  logic [7:0] x_sum;
  logic [6:0] y_sum;

  always_comb begin
    x_sum = {1'b0, x0} + {4'b0, col};
    y_sum = {1'b0, y0} + {3'b0, row};
    hpos  = x_sum[6:0];
    vpos  = y_sum[5:0];
    if (hires) begin
      clipped = (x_sum >= 8'(HIRES_W)) || (y_sum >= 7'(HIRES_H));
    end else begin
      clipped = (x_sum >= 8'(LORES_W)) || (y_sum >= 7'(LORES_H));
    end
  end
endmodule

// File: rtl/sprite_draw.sv
// sprite_draw
//   DXYN draw engine. On start it fetches the sprite bytes from RAM at I and
//   XORs every set bit into vram at (VX,VY), reporting whether any set bit
//   hit an already lit pixel.
//   Ports: clk, reset (async, active-low); start/vx/vy/n/i_addr/hires/plane
//          request from the cpu; busy/done/collision status back;
//          bus (sprite_draw_if.master) carries the RAM and vram ports.
//   Build option: XOCHIP_PLANES_EN enables multi-plane drawing (one pass per
//   set plane bit); otherwise plane is ignored and only plane 0 is drawn.
module sprite_draw
  import ghostchip_pkg::*;
#(
  parameter int RAM_AW  = 12,
  parameter int VRAM_XW = 7,
  parameter int VRAM_YW = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        vx,
  input  logic [7:0]        vy,
  input  logic [3:0]        n,
  input  logic [RAM_AW-1:0] i_addr,
  input  logic              hires,
  input  logic [1:0]        plane,
  output logic              busy,
  output logic              done,
  output logic              collision,
  sprite_draw_if.master     bus
);
  state_e             state_q, state_d;
  logic [RAM_AW-1:0]  addr_q, addr_d;
  logic [6:0]         x0_q, x0_d;
  logic [5:0]         y0_q, y0_d;
  logic               hires_q, hires_d;
  logic               wide_q, wide_d;
  logic [3:0]         last_row_q, last_row_d;
  logic [3:0]         col_q, col_d;
  logic [3:0]         row_q, row_d;
  logic [6:0]         sreg_q, sreg_d;
  logic [1:0]         mask_q, mask_d;
  logic               pend_q, pend_d;
  logic               coll_q, coll_d;
  logic [VRAM_XW-1:0] hpos_q, hpos_d;
  logic [VRAM_YW-1:0] vpos_q, vpos_d;

  logic               eval_go;
  logic               eval_bit;
  logic [3:0]         eval_col;
  logic [6:0]         clip_hpos;
  logic [5:0]         clip_vpos;
  logic               clip_out;
  logic               unused_bits;

`ifdef XOCHIP_PLANES_EN
  assign unused_bits = ^{vx[7], vy[7:6]};
`else
  assign unused_bits = ^{vx[7], vy[7:6], plane};
`endif

  // Which pixel is examined next. A new bit is looked at either as the
  // byte arrives (FWAIT, straight from ram_dout) or when the previous bit
  // retires inside a byte; deciding it here lets a set bit go straight to
  // the read cycle so it costs two cycles instead of three.
  always_comb begin
    eval_go  = 1'b0;
    eval_bit = 1'b0;
    eval_col = col_q;
    if (state_q == ST_FWAIT) begin
      eval_go  = 1'b1;
      eval_bit = bus.ram_dout[7];
    end else if ((state_q == ST_PIX || state_q == ST_PWR) && col_q[2:0] != 3'd7) begin
      eval_go  = 1'b1;
      eval_bit = sreg_q[6];
      eval_col = col_q + 4'd1;
    end
  end

  sprite_clip u_clip (
    .x0      (x0_q),
    .y0      (y0_q),
    .col     (eval_col),
    .row     (row_q),
    .hires   (hires_q),
    .hpos    (clip_hpos),
    .vpos    (clip_vpos),
    .clipped (clip_out)
  );

  // Next-state logic. The sprite address just increments across rows,
  // both halves of a 16-wide row and a second plane pass, so it wraps
  // naturally at the RAM size.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    hires_d    = hires_q;
    wide_d     = wide_q;
    last_row_d = last_row_q;
    col_d      = col_q;
    row_d      = row_q;
    sreg_d     = sreg_q;
    mask_d     = mask_q;
    pend_d     = pend_q;
    coll_d     = coll_q;
    hpos_d     = hpos_q;
    vpos_d     = vpos_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d     = i_addr;
          hires_d    = hires;
          wide_d     = (n == 4'd0);
          last_row_d = (n == 4'd0) ? 4'(SPR16_ROWS - 1) : n - 4'd1;
          x0_d       = hires ? vx[6:0] : {1'b0, vx[5:0]};
          y0_d       = hires ? vy[5:0] : {1'b0, vy[4:0]};
          col_d      = 4'd0;
          row_d      = 4'd0;
          coll_d     = 1'b0;
`ifdef XOCHIP_PLANES_EN
          mask_d     = plane[0] ? 2'b01 : 2'b10;
          pend_d     = &plane;
          state_d    = (plane == 2'b00) ? ST_DONE : ST_FETCH;
`else
          mask_d     = 2'b01;
          pend_d     = 1'b0;
          state_d    = ST_FETCH;
`endif
        end
      end
      ST_FETCH: state_d = ST_FWAIT;
      ST_FWAIT: sreg_d = bus.ram_dout[6:0];
      ST_PRD:   state_d = ST_PWR;
      ST_PIX, ST_PWR: begin
        if (state_q == ST_PWR && (bus.vram_pixelo & mask_q) != 2'b00) begin
          coll_d = 1'b1;
        end
        if (col_q[2:0] != 3'd7) begin
          col_d  = col_q + 4'd1;
          sreg_d = {sreg_q[5:0], 1'b0};
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_FETCH;
          if (wide_q && !col_q[3]) begin
            col_d = 4'd8;
          end else if (row_q != last_row_q) begin
            col_d = 4'd0;
            row_d = row_q + 4'd1;
          end else if (pend_q) begin
            col_d  = 4'd0;
            row_d  = 4'd0;
            pend_d = 1'b0;
            mask_d = 2'b10;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (eval_go) begin
      if (eval_bit && !clip_out) begin
        state_d = ST_PRD;
        hpos_d  = clip_hpos;
        vpos_d  = clip_vpos;
      end else begin
        state_d = ST_PIX;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      x0_q       <= '0;
      y0_q       <= '0;
      hires_q    <= 1'b0;
      wide_q     <= 1'b0;
      last_row_q <= '0;
      col_q      <= '0;
      row_q      <= '0;
      sreg_q     <= '0;
      mask_q     <= 2'b01;
      pend_q     <= 1'b0;
      coll_q     <= 1'b0;
      hpos_q     <= '0;
      vpos_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      hires_q    <= hires_d;
      wide_q     <= wide_d;
      last_row_q <= last_row_d;
      col_q      <= col_d;
      row_q      <= row_d;
      sreg_q     <= sreg_d;
      mask_q     <= mask_d;
      pend_q     <= pend_d;
      coll_q     <= coll_d;
      hpos_q     <= hpos_d;
      vpos_q     <= vpos_d;
    end
  end

  // The write strobe decodes the state register directly so a reset in the
  // middle of a draw removes it immediately rather than at the next edge.
  assign bus.ram_addr    = addr_q;
  assign bus.vram_hpos   = hpos_q;
  assign bus.vram_vpos   = vpos_q;
  assign bus.vram_we     = (state_q == ST_PWR);
  assign bus.vram_pixeli = (state_q == ST_PWR) ? (bus.vram_pixelo ^ mask_q) : 2'b00;
  assign busy            = state_q inside {ST_FETCH, ST_FWAIT, ST_PIX, ST_PRD, ST_PWR};
  assign done            = (state_q == ST_DONE);
  assign collision       = coll_q;
endmodule

// File: tb/tb_sprite_draw.sv
// tb_sprite_draw
//   Self-checking bench for sprite_draw. Table of draw requests, a spec-level
//   reference model producing the expected vram writes into a queue, and a
//   write monitor that pops and compares each vram write.
module tb_sprite_draw;

  typedef struct {
    logic       clr;
    logic       hires;
    logic [7:0] vx;
    logic [7:0] vy;
    logic [3:0] n;
    logic [11:0] iaddr;
    logic [1:0] plane;
    logic       restart_mid;
    int         exp_cycles;
    int         px;
    int         py;
    logic [1:0] pval;
  } vec_t;

  typedef struct packed {
    logic [6:0] h;
    logic [5:0] v;
    logic [1:0] d;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  vx;
  logic [7:0]  vy;
  logic [3:0]  n;
  logic [11:0] i_addr;
  logic        hires;
  logic [1:0]  plane;
  logic        busy;
  logic        done;
  logic        collision;
  logic        clr_req;

  logic [7:0] ram      [4096];
  logic [1:0] vmem     [128][64];
  logic [1:0] ref_vmem [128][64];
  wr_t        exp_q[$];
  vec_t       vecs[$];

  int n_cmp = 0;
  int n_bad = 0;

  sprite_draw_if #(.RAM_AW(12), .VRAM_XW(7), .VRAM_YW(6)) bus ();

  sprite_draw #(.RAM_AW(12), .VRAM_XW(7), .VRAM_YW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vx        (vx),
    .vy        (vy),
    .n         (n),
    .i_addr    (i_addr),
    .hires     (hires),
    .plane     (plane),
    .busy      (busy),
    .done      (done),
    .collision (collision),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory models: synchronous RAM read, synchronous vram read plus write.
  always @(posedge clk) begin
    if (clr_req) begin
      for (int x = 0; x < 128; x++) for (int y = 0; y < 64; y++) vmem[x][y] <= 2'b00;
    end else if (bus.vram_we === 1'b1) begin
      vmem[bus.vram_hpos][bus.vram_vpos] <= bus.vram_pixeli;
    end
    bus.vram_pixelo <= vmem[bus.vram_hpos][bus.vram_vpos];
    bus.ram_dout    <= ram[bus.ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every vram write is matched against the next expected write.
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.vram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_write", 32'({bus.vram_hpos, bus.vram_vpos, bus.vram_pixeli}), 32'hFFFF_FFFF);
      end else begin
        checkOutput("write", 32'({bus.vram_hpos, bus.vram_vpos, bus.vram_pixeli}), 32'(exp_q.pop_front()));
      end
    end
  end

  function automatic vec_t mk(logic clr, logic hr, logic [7:0] x, logic [7:0] y, logic [3:0] nn,
                              logic [11:0] ia, logic [1:0] pl, logic rm, int cyc,
                              int px, int py, logic [1:0] pv);
    vec_t v;
    v.clr = clr; v.hires = hr; v.vx = x; v.vy = y; v.n = nn; v.iaddr = ia; v.plane = pl;
    v.restart_mid = rm; v.exp_cycles = cyc; v.px = px; v.py = py; v.pval = pv;
    return v;
  endfunction

  task automatic clearVram();
    clr_req = 1'b1;
    @(posedge clk);
    #1 clr_req = 1'b0;
    for (int x = 0; x < 128; x++) for (int y = 0; y < 64; y++) ref_vmem[x][y] = 2'b00;
  endtask

  // Reference model straight from the draw description: origin wraps,
  // pixels past the edge are skipped, set bits XOR the plane mask.
  task automatic buildExpected(input vec_t v, output int cyc, output logic coll);
    int w, h, x0, y0, rows, bpr, k, x, y;
    logic [1:0] masks[$];
    logic [7:0] b;
    logic [1:0] old;
    wr_t e;
    w = v.hires ? 128 : 64;
    h = v.hires ? 64 : 32;
    x0 = int'(v.vx) % w;
    y0 = int'(v.vy) % h;
    rows = (v.n == 4'd0) ? 16 : int'(v.n);
    bpr = (v.n == 4'd0) ? 2 : 1;
`ifdef XOCHIP_PLANES_EN
    if (v.plane[0]) masks.push_back(2'b01);
    if (v.plane[1]) masks.push_back(2'b10);
`else
    masks.push_back(2'b01);
`endif
    cyc = 1;
    coll = 1'b0;
    k = 0;
    foreach (masks[p]) begin
      for (int r = 0; r < rows; r++) begin
        for (int bb = 0; bb < bpr; bb++) begin
          b = ram[(int'(v.iaddr) + k) % 4096];
          k++;
          cyc += 2;
          for (int i = 0; i < 8; i++) begin
            x = x0 + bb * 8 + i;
            y = y0 + r;
            if (!b[7 - i] || x >= w || y >= h) begin
              cyc += 1;
            end else begin
              cyc += 2;
              old = ref_vmem[x][y];
              if ((old & masks[p]) != 2'b00) coll = 1'b1;
              ref_vmem[x][y] = old ^ masks[p];
              e.h = 7'(x);
              e.v = 6'(y);
              e.d = old ^ masks[p];
              exp_q.push_back(e);
            end
          end
        end
      end
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int exp_cyc, cycles, busy_bad;
    logic exp_coll;
    if (v.clr) clearVram();
    buildExpected(v, exp_cyc, exp_coll);
    @(negedge clk);
    vx = v.vx; vy = v.vy; n = v.n; i_addr = v.iaddr; hires = v.hires; plane = v.plane;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 1;
    busy_bad = 0;
    while (done !== 1'b1 && cycles < 4000) begin
      if (busy !== 1'b1) busy_bad++;
      if (v.restart_mid && cycles == 3) begin
        start = 1'b1; vx = vx + 8'd5; vy = vy + 8'd3; n = 4'd3; i_addr = 12'h100;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1 cycles++;
    end
    start = 1'b0;
    checkOutput($sformatf("v%0d done", idx), 32'(done), 32'd1);
    checkOutput($sformatf("v%0d busy_at_done", idx), 32'(busy), 32'd0);
    checkOutput($sformatf("v%0d busy_gaps", idx), 32'(busy_bad), 32'd0);
    checkOutput($sformatf("v%0d cycles", idx), 32'(cycles), 32'(exp_cyc));
    if (v.exp_cycles != 0) checkOutput($sformatf("v%0d cycles_table", idx), 32'(cycles), 32'(v.exp_cycles));
    checkOutput($sformatf("v%0d collision", idx), 32'(collision), 32'(exp_coll));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d done_pulse", idx), 32'(done), 32'd0);
    checkOutput($sformatf("v%0d probe", idx), 32'(vmem[v.px][v.py]), 32'(v.pval));
    checkOutput($sformatf("v%0d writes_left", idx), 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int writes_seen;
    int exp_cyc;
    logic exp_coll;
    for (int j = 0; j < 4096; j++) ram[j] = 8'(j * 29 + 90);
    ram[12'h100] = 8'h80;
    ram[12'h101] = 8'h80;
    ram[12'h200] = 8'hFF;
    ram[12'hFFF] = 8'hFF;
    ram[12'h300] = 8'hC3;
    ram[12'h301] = 8'h3C;

    vecs.push_back(mk(1, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b01, 0, 12, 0,   0,  2'b01));
    vecs.push_back(mk(0, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b01, 0, 12, 0,   0,  2'b00));
    vecs.push_back(mk(0, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b01, 0, 12, 0,   0,  2'b01));
    vecs.push_back(mk(1, 0, 8'd70,  8'd33, 4'd1,  12'h200, 2'b01, 0, 19, 13,  1,  2'b01));
    vecs.push_back(mk(1, 0, 8'd60,  8'd0,  4'd1,  12'h200, 2'b01, 0, 15, 3,   0,  2'b00));
    vecs.push_back(mk(1, 1, 8'd120, 8'd60, 4'd0,  12'hFFF, 2'b01, 1, 0,  120, 60, 2'b01));
    vecs.push_back(mk(1, 1, 8'd200, 8'd70, 4'd2,  12'h300, 2'b01, 0, 29, 72,  6,  2'b01));
    vecs.push_back(mk(1, 0, 8'd10,  8'd31, 4'd2,  12'h300, 2'b01, 0, 25, 10,  31, 2'b01));
    vecs.push_back(mk(1, 1, 8'd5,   8'd9,  4'd15, 12'h010, 2'b01, 0, 0,  0,   0,  2'b00));
`ifdef XOCHIP_PLANES_EN
    vecs.push_back(mk(1, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b11, 0, 23, 0,   0,  2'b11));
    vecs.push_back(mk(0, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b00, 0, 1,  0,   0,  2'b11));
    vecs.push_back(mk(0, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b10, 0, 12, 0,   0,  2'b01));
`else
    vecs.push_back(mk(1, 0, 8'd0,   8'd0,  4'd1,  12'h100, 2'b10, 0, 12, 0,   0,  2'b01));
`endif

    reset = 1'b0; start = 1'b0; vx = '0; vy = '0; n = '0; i_addr = '0;
    hires = 1'b0; plane = 2'b01; clr_req = 1'b0;
    repeat (2) @(posedge clk);
    clearVram();
    #1;
    checkOutput("rst busy", 32'(busy), 32'd0);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst collision", 32'(collision), 32'd0);
    checkOutput("rst we", 32'(bus.vram_we), 32'd0);
    checkOutput("rst ram_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("rst hpos", 32'(bus.vram_hpos), 32'd0);
    checkOutput("rst vpos", 32'(bus.vram_vpos), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Reset in the middle of a row: the strobe must vanish before the
    // pending write edge, leaving the earlier pixels in place.
    clearVram();
    buildExpected(mk(0, 0, 8'd0, 8'd0, 4'd1, 12'h200, 2'b01, 0, 0, 0, 0, 2'b00), exp_cyc, exp_coll);
    @(negedge clk);
    vx = 8'd0; vy = 8'd0; n = 4'd1; i_addr = 12'h200; hires = 1'b0; plane = 2'b01;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    writes_seen = 0;
    for (int c = 0; c < 40 && writes_seen < 3; c++) begin
      @(negedge clk);
      if (bus.vram_we === 1'b1) writes_seen++;
    end
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst writes_seen", 32'(writes_seen), 32'd3);
    checkOutput("midrst we", 32'(bus.vram_we), 32'd0);
    checkOutput("midrst busy", 32'(busy), 32'd0);
    checkOutput("midrst hpos", 32'(bus.vram_hpos), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst kept_px1", 32'(vmem[1][0]), 32'd1);
    checkOutput("midrst no_px2", 32'(vmem[2][0]), 32'd0);

    applyStimulus(mk(1, 0, 8'd0, 8'd0, 4'd1, 12'h100, 2'b01, 0, 12, 0, 0, 2'b01), 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
